l2_snoop_responder: RTL and testbench
=====================================

// Module: l2_snoop_responder
// PURPOSE
// - Bus-side responder for the L2 MESI snoop protocol: accepts snooped bus ops (READ, WRITE, RWIM, INVALIDATE) from other
//   processors, looks up the local L2 tag/MESI array, returns HIT/HITM/NOHIT and applies the MESI transition.
// - On HITM it issues the line writeback; on transition to I it sends the L1 invalidate message, keeping L1 inclusive.
// - It answers the snoop results the L2 request path collects; one snoop is in flight at a time.
// PARAMETERS
// - ADDR_W    32  bus address width
// - OFFSET_W   6  byte-offset bits (64 B line)
// - INDEX_W   14  set-index bits; TAG_W = ADDR_W-INDEX_W-OFFSET_W (12 at defaults)
// - WAY_W      3  way-select width (8 ways)
// PORTS
// - clk          in   1        clock, all state updates on rising edge
// - rst_n        in   1        asynchronous active-low reset
// - snp_valid    in   1        snoop request present
// - snp_ready    out  1        responder idle, request accepted when snp_valid&snp_ready
// - snp_op       in   2        00 READ, 01 WRITE, 10 RWIM, 11 INVALIDATE
// - snp_addr     in   ADDR_W   snooped address
// - rsp_valid    out  1        one-cycle pulse, rsp_code valid
// - rsp_code     out  2        00 NOHIT, 01 HIT, 10 HITM (11 never driven)
// - lu_req       out  1        tag lookup request, held until lu_ack
// - lu_index     out  INDEX_W  lookup set
// - lu_tag       out  TAG_W    lookup tag
// - lu_ack       in   1        lookup result valid (latency >=1, unbounded)
// - lu_hit       in   1        tag match with MESI != I
// - lu_way       in   WAY_W    matching way
// - lu_mesi      in   2        00 I, 01 S, 10 E, 11 M
// - upd_valid    out  1        one-cycle MESI write strobe
// - upd_index/upd_way/upd_mesi out INDEX_W/WAY_W/2  MESI write target and new state
// - wb_req       out  1        writeback request, held until wb_ack; wb_addr out ADDR_W = line-aligned snp_addr
// - wb_ack       in   1        writeback accepted
// - l1_inv       out  1        L1 invalidate request, held until l1_ack; l1_addr out ADDR_W = line-aligned addr
// - l1_ack       in   1        L1 invalidate accepted
// - hit_cnt/hitm_cnt/nohit_cnt out 16 each  statistics (see CONFIGURATION)
// BEHAVIOUR
// - Reset (async, any state): FSM->IDLE; snp_ready=1 after release; every other output 0; latched op/addr cleared.
// - FSM: IDLE -> LOOKUP -> RESPOND -> [WB] -> [L1INV] -> IDLE.
// - IDLE: snp_ready=1; on accept latch op/addr, go LOOKUP; snp_ready=0 in all other states.
// - LOOKUP: lu_req=1, lu_index=addr[OFFSET_W+:INDEX_W], lu_tag=addr[ADDR_W-1-:TAG_W]; on lu_ack latch hit/way/mesi, lu_req
//   drops next cycle, go RESPOND. lu_ack outside LOOKUP ignored.
// - RESPOND (one cycle): rsp_valid=1, rsp_code per table; upd_valid=1 only if state changes; next WB if HITM, else L1INV if
//   new state I and old != I, else IDLE.
//   miss/I, any op       -> NOHIT, no update
//   READ  S/E -> S HIT;  M -> S HITM
//   WRITE S/E/M          -> NOHIT, no update (foreign writeback cannot hit a valid line; state untouched)
//   RWIM  S/E -> I HIT;  M -> I HITM
//   INV   S/E/M -> I HIT (M treated as protocol error, line dropped without writeback)
// - WB: wb_req=1 until wb_ack sampled high; same-cycle wb_ack exits; then L1INV if new state I, else IDLE.
// - L1INV: l1_inv=1 until l1_ack sampled high, then IDLE.
// - Latency: accept->rsp_valid = lookup latency + 1 cycle; back-to-back snoop accepted the cycle after return to IDLE.
// - snp_valid held during busy states is not accepted; request data must stay stable until accepted.
// CONFIGURATION
// - SNOOP_STATS_EN defined: hit_cnt/hitm_cnt/nohit_cnt increment in RESPOND per rsp_code, saturate at 16'hFFFF, reset to 0.
// - SNOOP_STATS_EN undefined: counter logic omitted; the three ports remain and are tied 0.
// TESTING
// - READ addr 32'h0040_1A40, lu_hit=1 mesi=M way=5 -> rsp HITM, upd mesi=S way=5, wb_req addr 32'h0040_1A40, no l1_inv.
// - RWIM same line mesi=E -> rsp HIT, upd mesi=I, no wb_req, l1_inv addr 32'h0040_1A40 held until l1_ack.
// - RWIM mesi=M, wb_ack delayed 4 cycles -> wb_req held 4 cycles, then l1_inv; snp_ready=0 throughout.
// - WRITE any addr lu_hit=0 -> rsp NOHIT, upd_valid/wb_req/l1_inv never asserted, back to IDLE next cycle.
// - rst_n low while in WB -> all outputs 0 immediately, snp_ready=1 after release, next READ handled normally.
// - SNOOP_STATS_EN: 3 HIT, 2 HITM, 1 NOHIT -> hit_cnt=3, hitm_cnt=2, nohit_cnt=1; undefined build -> all 0.

Source files
------------

// File: rtl/l2_snoop_responder.sv
// L2 MESI snoop responder: lookup, HIT/HITM/NOHIT reply, MESI update, writeback and L1 invalidate sequencing.
// One snoop in flight; optional statistics counters enabled by defining SNOOP_STATS_EN.
module l2_snoop_responder #(
  parameter int ADDR_W   = 32,
  parameter int OFFSET_W = 6,
  parameter int INDEX_W  = 14,
  parameter int WAY_W    = 3,
  localparam int TAG_W   = ADDR_W - INDEX_W - OFFSET_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               snp_valid,
  output logic               snp_ready,
  input  logic [1:0]         snp_op,
  input  logic [ADDR_W-1:0]  snp_addr,
  output logic               rsp_valid,
  output logic [1:0]         rsp_code,
  output logic               lu_req,
  output logic [INDEX_W-1:0] lu_index,
  output logic [TAG_W-1:0]   lu_tag,
  input  logic               lu_ack,
  input  logic               lu_hit,
  input  logic [WAY_W-1:0]   lu_way,
  input  logic [1:0]         lu_mesi,
  output logic               upd_valid,
  output logic [INDEX_W-1:0] upd_index,
  output logic [WAY_W-1:0]   upd_way,
  output logic [1:0]         upd_mesi,
  output logic               wb_req,
  output logic [ADDR_W-1:0]  wb_addr,
  input  logic               wb_ack,
  output logic               l1_inv,
  output logic [ADDR_W-1:0]  l1_addr,
  input  logic               l1_ack,
  output logic [15:0]        hit_cnt,
  output logic [15:0]        hitm_cnt,
  output logic [15:0]        nohit_cnt
);

  typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_RESPOND, S_WB, S_L1INV} state_t;

  localparam logic [1:0] OP_READ   = 2'b00;
  localparam logic [1:0] OP_RWIM   = 2'b10;
  localparam logic [1:0] OP_INV    = 2'b11;
  localparam logic [1:0] MESI_I    = 2'b00;
  localparam logic [1:0] MESI_S    = 2'b01;
  localparam logic [1:0] MESI_M    = 2'b11;
  localparam logic [1:0] RSP_NOHIT = 2'b00;
  localparam logic [1:0] RSP_HIT   = 2'b01;
  localparam logic [1:0] RSP_HITM  = 2'b10;
  localparam logic [ADDR_W-1:0] LINE_MASK = {ADDR_W{1'b1}} << OFFSET_W;

  state_t             state_q;
  logic [1:0]         op_q;
  logic [ADDR_W-1:0]  addr_q;
  logic               hit_q;
  logic [WAY_W-1:0]   way_q;
  logic [1:0]         mesi_q;
  logic [1:0]         new_mesi_q;
  logic [1:0]         rsp_code_q;
  logic               rsp_valid_q;
  logic               upd_valid_q;
  logic               snp_ready_q;
  logic               lu_req_q;
  logic               wb_req_q;
  logic               l1_inv_q;

  logic [1:0]         rsp_code_d;
  logic [1:0]         new_mesi_d;
  logic               upd_d;
  logic               l1_need;

  // Response and next MESI state straight from the lookup result, captured on lu_ack.
  always_comb begin
    rsp_code_d = RSP_NOHIT;
    new_mesi_d = lu_mesi;
    if (lu_hit && lu_mesi != MESI_I) begin
      case (op_q)
        OP_READ: begin
          new_mesi_d = MESI_S;
          rsp_code_d = (lu_mesi == MESI_M) ? RSP_HITM : RSP_HIT;
        end
        OP_RWIM: begin
          new_mesi_d = MESI_I;
          rsp_code_d = (lu_mesi == MESI_M) ? RSP_HITM : RSP_HIT;
        end
        OP_INV: begin
          new_mesi_d = MESI_I;
          rsp_code_d = RSP_HIT;
        end
        default: ;
      endcase
    end
    upd_d = (new_mesi_d != lu_mesi);
  end

  assign l1_need = hit_q && (mesi_q != MESI_I) && (new_mesi_q == MESI_I);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      op_q        <= 2'b00;
      addr_q      <= '0;
      hit_q       <= 1'b0;
      way_q       <= '0;
      mesi_q      <= MESI_I;
      new_mesi_q  <= MESI_I;
      rsp_code_q  <= RSP_NOHIT;
      rsp_valid_q <= 1'b0;
      upd_valid_q <= 1'b0;
      snp_ready_q <= 1'b1;
      lu_req_q    <= 1'b0;
      wb_req_q    <= 1'b0;
      l1_inv_q    <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      upd_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (snp_valid && snp_ready_q) begin
            op_q        <= snp_op;
            addr_q      <= snp_addr;
            snp_ready_q <= 1'b0;
            lu_req_q    <= 1'b1;
            state_q     <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (lu_ack) begin
            lu_req_q    <= 1'b0;
            hit_q       <= lu_hit;
            way_q       <= lu_way;
            mesi_q      <= lu_mesi;
            new_mesi_q  <= new_mesi_d;
            rsp_code_q  <= rsp_code_d;
            rsp_valid_q <= 1'b1;
            upd_valid_q <= upd_d;
            state_q     <= S_RESPOND;
          end
        end
        S_RESPOND: begin
          if (rsp_code_q == RSP_HITM) begin
            wb_req_q <= 1'b1;
            state_q  <= S_WB;
          end else if (l1_need) begin
            l1_inv_q <= 1'b1;
            state_q  <= S_L1INV;
          end else begin
            snp_ready_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        S_WB: begin
          if (wb_ack) begin
            wb_req_q <= 1'b0;
            if (l1_need) begin
              l1_inv_q <= 1'b1;
              state_q  <= S_L1INV;
            end else begin
              snp_ready_q <= 1'b1;
              state_q     <= S_IDLE;
            end
          end
        end
        S_L1INV: begin
          if (l1_ack) begin
            l1_inv_q    <= 1'b0;
            snp_ready_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          snp_ready_q <= 1'b1;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign snp_ready = snp_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_code  = rsp_code_q;
  assign lu_req    = lu_req_q;
  assign lu_index  = addr_q[OFFSET_W +: INDEX_W];
  assign lu_tag    = addr_q[ADDR_W-1 -: TAG_W];
  assign upd_valid = upd_valid_q;
  assign upd_index = addr_q[OFFSET_W +: INDEX_W];
  assign upd_way   = way_q;
  assign upd_mesi  = new_mesi_q;
  assign wb_req    = wb_req_q;
  assign wb_addr   = addr_q & LINE_MASK;
  assign l1_inv    = l1_inv_q;
  assign l1_addr   = addr_q & LINE_MASK;

`ifdef SNOOP_STATS_EN
  logic [15:0] hit_cnt_q;
  logic [15:0] hitm_cnt_q;
  logic [15:0] nohit_cnt_q;

  // Saturating counters, one bump per response cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_q   <= 16'h0000;
      hitm_cnt_q  <= 16'h0000;
      nohit_cnt_q <= 16'h0000;
    end else if (state_q == S_RESPOND) begin
      if (rsp_code_q == RSP_HIT && hit_cnt_q != 16'hFFFF)
        hit_cnt_q <= hit_cnt_q + 16'd1;
      if (rsp_code_q == RSP_HITM && hitm_cnt_q != 16'hFFFF)
        hitm_cnt_q <= hitm_cnt_q + 16'd1;
      if (rsp_code_q == RSP_NOHIT && nohit_cnt_q != 16'hFFFF)
        nohit_cnt_q <= nohit_cnt_q + 16'd1;
    end
  end

  assign hit_cnt   = hit_cnt_q;
  assign hitm_cnt  = hitm_cnt_q;
  assign nohit_cnt = nohit_cnt_q;
`else
  assign hit_cnt   = 16'h0000;
  assign hitm_cnt  = 16'h0000;
  assign nohit_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_l2_snoop_responder.sv
// Randomized bench for l2_snoop_responder against a table-driven MESI snoop model.
module tb_l2_snoop_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        snp_valid = 1'b0;
  logic        snp_ready;
  logic [1:0]  snp_op = 2'b00;
  logic [31:0] snp_addr = 32'h0;
  logic        rsp_valid;
  logic [1:0]  rsp_code;
  logic        lu_req;
  logic [13:0] lu_index;
  logic [11:0] lu_tag;
  logic        lu_ack = 1'b0;
  logic        lu_hit = 1'b0;
  logic [2:0]  lu_way = 3'd0;
  logic [1:0]  lu_mesi = 2'b00;
  logic        upd_valid;
  logic [13:0] upd_index;
  logic [2:0]  upd_way;
  logic [1:0]  upd_mesi;
  logic        wb_req;
  logic [31:0] wb_addr;
  logic        wb_ack = 1'b0;
  logic        l1_inv;
  logic [31:0] l1_addr;
  logic        l1_ack = 1'b0;
  logic [15:0] hit_cnt, hitm_cnt, nohit_cnt;

  int total = 0;
  int bad = 0;
  int n_hit = 0, n_hitm = 0, n_nohit = 0;

  l2_snoop_responder dut (
    .clk(clk), .rst_n(rst_n),
    .snp_valid(snp_valid), .snp_ready(snp_ready), .snp_op(snp_op), .snp_addr(snp_addr),
    .rsp_valid(rsp_valid), .rsp_code(rsp_code),
    .lu_req(lu_req), .lu_index(lu_index), .lu_tag(lu_tag),
    .lu_ack(lu_ack), .lu_hit(lu_hit), .lu_way(lu_way), .lu_mesi(lu_mesi),
    .upd_valid(upd_valid), .upd_index(upd_index), .upd_way(upd_way), .upd_mesi(upd_mesi),
    .wb_req(wb_req), .wb_addr(wb_addr), .wb_ack(wb_ack),
    .l1_inv(l1_inv), .l1_addr(l1_addr), .l1_ack(l1_ack),
    .hit_cnt(hit_cnt), .hitm_cnt(hitm_cnt), .nohit_cnt(nohit_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // MESI snoop table: ops 0 READ 1 WRITE 2 RWIM 3 INV; states 0 I 1 S 2 E 3 M; codes 0 NOHIT 1 HIT 2 HITM.
  task automatic model(input logic [1:0] op, input logic hit, input logic [1:0] mesi,
                       output logic [1:0] code, output logic upd, output logic [1:0] nm,
                       output logic wb, output logic l1);
    logic present;
    present = hit && (mesi != 2'd0);
    code = 2'd0;
    nm   = mesi;
    if (present && op == 2'd0) begin
      nm = 2'd1; code = (mesi == 2'd3) ? 2'd2 : 2'd1;
    end else if (present && op == 2'd2) begin
      nm = 2'd0; code = (mesi == 2'd3) ? 2'd2 : 2'd1;
    end else if (present && op == 2'd3) begin
      nm = 2'd0; code = 2'd1;
    end
    upd = (nm != mesi);
    wb  = (code == 2'd2);
    l1  = present && (nm == 2'd0);
  endtask

  task automatic count_rsp(input logic [1:0] code);
    if (code == 2'd1) n_hit++;
    else if (code == 2'd2) n_hitm++;
    else n_nohit++;
  endtask

  task automatic chk_stats(input string tag);
`ifdef SNOOP_STATS_EN
    chk({tag, "_hit"},   {16'h0, hit_cnt},   n_hit);
    chk({tag, "_hitm"},  {16'h0, hitm_cnt},  n_hitm);
    chk({tag, "_nohit"}, {16'h0, nohit_cnt}, n_nohit);
`else
    chk({tag, "_hit"},   {16'h0, hit_cnt},   0);
    chk({tag, "_hitm"},  {16'h0, hitm_cnt},  0);
    chk({tag, "_nohit"}, {16'h0, nohit_cnt}, 0);
`endif
  endtask

  // Full snoop transaction; called and returns at a falling edge with the DUT idle.
  task automatic do_snoop(input logic [1:0] op, input logic [31:0] addr, input logic hit,
                          input logic [2:0] way, input logic [1:0] mesi,
                          input int lu_dly, input int wb_dly, input int l1_dly, input logic hold_junk);
    logic [1:0] e_code, e_nm;
    logic e_upd, e_wb, e_l1;
    model(op, hit, mesi, e_code, e_upd, e_nm, e_wb, e_l1);
    chk("idle_ready", {31'h0, snp_ready}, 1);
    snp_valid = 1'b1; snp_op = op; snp_addr = addr;
    @(negedge clk);
    snp_valid = hold_junk; snp_op = 2'($urandom); snp_addr = $urandom;
    chk("lu_req", {31'h0, lu_req}, 1);
    chk("busy_ready", {31'h0, snp_ready}, 0);
    chk("lu_index", {18'h0, lu_index}, (addr >> 6) & 32'h3FFF);
    chk("lu_tag", {20'h0, lu_tag}, addr >> 20);
    for (int i = 0; i < lu_dly; i++) begin
      @(negedge clk);
      chk("lu_wait", {30'h0, lu_req, rsp_valid}, 2);
    end
    lu_ack = 1'b1; lu_hit = hit; lu_way = way; lu_mesi = mesi;
    @(negedge clk);
    lu_ack = 1'b0; lu_hit = 1'($urandom); lu_way = 3'($urandom); lu_mesi = 2'($urandom);
    snp_valid = 1'b0;
    chk("rsp_valid", {31'h0, rsp_valid}, 1);
    chk("rsp_code", {30'h0, rsp_code}, e_code);
    chk("upd_valid", {31'h0, upd_valid}, e_upd);
    chk("lu_req_drop", {31'h0, lu_req}, 0);
    if (e_upd) begin
      chk("upd_mesi", {30'h0, upd_mesi}, e_nm);
      chk("upd_way", {29'h0, upd_way}, way);
      chk("upd_index", {18'h0, upd_index}, (addr >> 6) & 32'h3FFF);
    end
    count_rsp(e_code);
    @(negedge clk);
    chk("rsp_pulse", {30'h0, rsp_valid, upd_valid}, 0);
    chk("wb_req", {31'h0, wb_req}, e_wb);
    if (e_wb) begin
      chk("wb_addr", wb_addr, addr & 32'hFFFF_FFC0);
      for (int i = 0; i < wb_dly; i++) begin
        @(negedge clk);
        chk("wb_hold", {30'h0, wb_req, snp_ready}, 2);
      end
      wb_ack = 1'b1;
      @(negedge clk);
      wb_ack = 1'b0;
      chk("wb_drop", {31'h0, wb_req}, 0);
    end
    chk("l1_inv", {31'h0, l1_inv}, e_l1);
    if (e_l1) begin
      chk("l1_addr", l1_addr, addr & 32'hFFFF_FFC0);
      for (int i = 0; i < l1_dly; i++) begin
        @(negedge clk);
        chk("l1_hold", {30'h0, l1_inv, snp_ready}, 2);
      end
      l1_ack = 1'b1;
      @(negedge clk);
      l1_ack = 1'b0;
    end
    chk("end_state", {27'h0, snp_ready, lu_req, wb_req, l1_inv, rsp_valid}, 32'h10);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    chk("rst_outs", {25'h0, rsp_valid, lu_req, upd_valid, wb_req, l1_inv, rsp_code}, 0);
    chk("rst_addr", wb_addr | l1_addr, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", {31'h0, snp_ready}, 1);
    chk_stats("rst_stats");

    // Directed cases on line 0x0040_1A40.
    do_snoop(2'd0, 32'h0040_1A40, 1'b1, 3'd5, 2'd3, 0, 1, 0, 1'b0);
    do_snoop(2'd2, 32'h0040_1A40, 1'b1, 3'd2, 2'd2, 1, 0, 2, 1'b0);
    do_snoop(2'd2, 32'h0040_1A40, 1'b1, 3'd1, 2'd3, 2, 4, 1, 1'b1);
    do_snoop(2'd1, 32'h1234_5678, 1'b0, 3'd0, 2'd3, 0, 0, 0, 1'b0);
    chk_stats("dir_stats");

    // Reset while a writeback is outstanding.
    snp_valid = 1'b1; snp_op = 2'd0; snp_addr = 32'hABCD_0040;
    @(negedge clk);
    snp_valid = 1'b0;
    lu_ack = 1'b1; lu_hit = 1'b1; lu_way = 3'd7; lu_mesi = 2'd3;
    @(negedge clk);
    lu_ack = 1'b0;
    @(negedge clk);
    chk("pre_rst_wb", {31'h0, wb_req}, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_wb_outs", {26'h0, rsp_valid, lu_req, upd_valid, wb_req, l1_inv, 1'b0}, 0);
    chk("rst_wb_addr", wb_addr, 0);
    n_hit = 0; n_hitm = 0; n_nohit = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_wb_ready", {31'h0, snp_ready}, 1);
    chk_stats("rst_wb_stats");

    // 3 HIT, 2 HITM, 1 NOHIT after reset.
    do_snoop(2'd0, 32'h0000_1000, 1'b1, 3'd3, 2'd2, 0, 0, 0, 1'b0);
    do_snoop(2'd2, 32'h0000_2000, 1'b1, 3'd4, 2'd1, 1, 0, 0, 1'b0);
    do_snoop(2'd3, 32'h0000_3000, 1'b1, 3'd6, 2'd3, 0, 0, 1, 1'b0);
    do_snoop(2'd0, 32'h0000_4000, 1'b1, 3'd0, 2'd3, 0, 2, 0, 1'b0);
    do_snoop(2'd2, 32'h0000_5000, 1'b1, 3'd1, 2'd3, 1, 1, 1, 1'b0);
    do_snoop(2'd1, 32'h0000_6000, 1'b1, 3'd2, 2'd3, 0, 0, 0, 1'b0);
`ifdef SNOOP_STATS_EN
    chk("cnt_hit", {16'h0, hit_cnt}, 3);
    chk("cnt_hitm", {16'h0, hitm_cnt}, 2);
    chk("cnt_nohit", {16'h0, nohit_cnt}, 1);
`else
    chk_stats("off_stats");
`endif

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        // Stray acknowledges while idle must be ignored.
        lu_ack = 1'b1; wb_ack = 1'($urandom); l1_ack = 1'($urandom);
        @(negedge clk);
        lu_ack = 1'b0; wb_ack = 1'b0; l1_ack = 1'b0;
        chk("stray_ack", {27'h0, snp_ready, lu_req, rsp_valid, wb_req, l1_inv}, 32'h10);
      end
      do_snoop(2'($urandom), $urandom, ($urandom_range(0, 3) != 0), 3'($urandom), 2'($urandom),
               $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));
    end
    chk_stats("final_stats");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
